dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder serving the core's load/store port: accepts one request (addr, wdata,
//  size, we) via valid/ready, waits a programmable latency, then returns load data or write ack.
//  Byte/half/word access with RV32 lane selection and sign extension; flags misaligned and
//  out-of-range accesses. Sits between the datapath's ALUResult/WriteData/ReadData and the RAM.
// PARAMETERS
//  DEPTH_WORDS  256  memory size in 32-bit words (power of 2, >=4)
//  LATENCY      2    cycles from request accept to rsp_valid (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low (0 = in reset)
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept (IDLE only)
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified (byte/half in low bits)
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   loads: 1 = zero-extend (lbu/lhu), 0 = sign-extend
//  rsp_valid    out  1   response present; held until rsp_ready
//  rsp_ready    in   1   consumer accepts response
//  rsp_rdata    out  32  load result (0 for stores and errors)
//  rsp_err      out  1   misaligned, illegal size, or out-of-range
// BEHAVIOUR
//  Reset: state IDLE, counter 0, req_ready=1 after reset release, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0; during reset req_ready=0. RAM contents not reset.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: req_ready=1; on req_valid at edge T capture all req_* fields. LATENCY=1 -> RESP,
//    else BUSY with counter=LATENCY-2.
//   BUSY: req_ready=0; counter decrements each cycle; at 0 -> RESP.
//   RESP: rsp_valid=1 from cycle T+LATENCY; rsp_rdata/rsp_err stable until handshake;
//    rsp_valid&&rsp_ready -> IDLE (no back-to-back accept in the same cycle; next
//    accept earliest one cycle later). Throughput: one access per LATENCY+1 cycles min.
//  Word index = addr[$clog2(DEPTH_WORDS)+1:2]; out-of-range if addr[31:2] >= DEPTH_WORDS.
//  Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Size 11 is an error.
//  Error: rsp_err=1, rsp_rdata=0, no RAM write; same latency as a normal access.
//  Store: committed on the edge entering RESP; byte enables from size/addr[1:0]
//   (byte: lane addr[1:0]; half: lanes {addr[1],0}+1..0; word: all); wdata low bits
//   replicated onto selected lanes; unselected bytes unchanged. rsp_rdata=0.
//  Load: RAM word read at entry to RESP; lane selected by addr[1:0]; sign bit = bit 7/15
//   of lane unless req_unsigned; word loads ignore req_unsigned.
//  Inputs while not IDLE are ignored (req_ready=0); req_* may change freely.
//  Reset mid-operation: return to IDLE immediately; store not yet committed is dropped;
//   pending response discarded.
// TESTING
//  1 sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at T+2.
//  2 after (1) lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x10 -> 0xFFFFBEEF.
//  3 sb 0x55 @0x11 over 0xDEADBEEF, lw @0x10 -> 0xDEAD55EF.
//  4 lw @0x12, sh @0x11, lw @0x400 (DEPTH 256) -> rsp_err=1, rdata=0, RAM @0x10 unchanged.
//  5 hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0; LATENCY=1 run -> valid at T+1.
//  6 assert reset in BUSY of sw @0x20 -> rsp_valid=0, req_ready=1 after release, @0x20 unchanged.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request and response channel between the core datapath and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one byte/half/word load or store at a time, with lane select and error flags.
// Response LATENCY cycles after accept; response held until rsp_ready, no new accept until then.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int AW       = $clog2(DEPTH_WORDS);
    localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam int CW       = (CNT_INIT > 0) ? $clog2(CNT_INIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
    } req_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    req_t          cap, cur;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept, enter_resp, err, commit;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wrep, rword, lane, ldat;
    logic [31:0]   rdata_q;
    logic          err_q;

    assign accept = bus.req_ready && bus.req_valid;

    // In IDLE the live request is used so a LATENCY=1 access can complete on its accept edge.
    always_comb begin
        cur = cap;
        if (state == IDLE) begin
            cur.we    = bus.req_we;
            cur.addr  = bus.req_addr;
            cur.wdata = bus.req_wdata;
            cur.size  = bus.req_size;
            cur.uns   = bus.req_unsigned;
        end
    end

    assign enter_resp = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == '0));

    always_comb begin
        err = 1'b0;
        case (cur.size)
            2'd1:    err = cur.addr[0];
            2'd2:    err = (cur.addr[1:0] != 2'b00);
            2'd3:    err = 1'b1;
            default: err = 1'b0;
        endcase
        if (|cur.addr[31:AW+2])
            err = 1'b1;
    end

    assign idx    = cur.addr[AW+1:2];
    assign commit = enter_resp && cur.we && !err && reset;

    always_comb begin
        be   = 4'b0000;
        wrep = cur.wdata;
        case (cur.size)
            2'd0: begin
                be   = 4'b0001 << cur.addr[1:0];
                wrep = {4{cur.wdata[7:0]}};
            end
            2'd1: begin
                be   = cur.addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{cur.wdata[15:0]}};
            end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rword = mem[idx];
    assign lane  = rword >> {cur.addr[1:0], 3'b000};

    always_comb begin
        case (cur.size)
            2'd0:    ldat = {{24{~cur.uns & lane[7]}}, lane[7:0]};
            2'd1:    ldat = {{16{~cur.uns & lane[15]}}, lane[15:0]};
            default: ldat = rword;
        endcase
    end

    // RAM has no reset; only committed, error-free stores touch it.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (cnt == '0) state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) && reset;
        bus.rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            cap     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cap <= cur;
                cnt <= CW'(CNT_INIT);
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_resp) begin
                rdata_q <= (err || cur.we) ? 32'h0 : ldat;
                err_q   <= err;
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) share the same stimulus and handshakes.
module tb_dmem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        rsp_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mref [DEPTH*4];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    assign bus0.req_valid = req_valid;    assign bus1.req_valid = req_valid;
    assign bus0.req_we = req_we;          assign bus1.req_we = req_we;
    assign bus0.req_addr = req_addr;      assign bus1.req_addr = req_addr;
    assign bus0.req_wdata = req_wdata;    assign bus1.req_wdata = req_wdata;
    assign bus0.req_size = req_size;      assign bus1.req_size = req_size;
    assign bus0.req_unsigned = req_unsigned; assign bus1.req_unsigned = req_unsigned;
    assign bus0.rsp_ready = rsp_ready;    assign bus1.rsp_ready = rsp_ready;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference memory: little-endian, sign-extend from the top loaded byte.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [31:0] rd, output logic e);
        int n;
        logic [31:0] v;
        n = 1 << size;
        e = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
        rd = 32'h0;
        if (!e) begin
            if (we) begin
                for (int b = 0; b < n; b++) mref[int'(addr) + b] = wdata[8*b +: 8];
            end else begin
                v = 32'h0;
                for (int b = 0; b < n; b++) v[8*b +: 8] = mref[int'(addr) + b];
                if (!uns && n < 4 && v[8*n-1])
                    for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
                rd = v;
            end
        end
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] rd0, output logic e0,
                          output logic [31:0] rd1, output logic e1);
        int lat0, lat1, n;
        chk("req_ready_idle0", 32'(bus0.req_ready), 32'd1);
        chk("req_ready_idle1", 32'(bus1.req_ready), 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
        lat0 = 0; lat1 = 0; n = 0;
        while (lat0 == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("req_ready_busy", 32'(bus0.req_ready), 32'd0);
            if (bus1.rsp_valid && lat1 == 0) lat1 = n;
            if (bus0.rsp_valid) lat0 = n;
        end
        chk("latency0", 32'(lat0), 32'd2);
        chk("latency1", 32'(lat1), 32'd1);
        rd0 = bus0.rsp_rdata; e0 = bus0.rsp_err;
        rd1 = bus1.rsp_rdata; e1 = bus1.rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_after_hs", 32'({bus0.rsp_valid, bus1.rsp_valid}), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [31:0] rd0, rd1, mrd, held;
        logic e0, e1, me, we, uns;
        logic [31:0] addr;
        logic [1:0] size;
        int nb;

        vt[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 2'd2, 1'b0, 32'h00000000, 1'b0};
        vt[1]  = '{1'b0, 32'h010, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b0, 32'h013, 32'h0,        2'd0, 1'b0, 32'hFFFFFFDE, 1'b0};
        vt[3]  = '{1'b0, 32'h013, 32'h0,        2'd0, 1'b1, 32'h000000DE, 1'b0};
        vt[4]  = '{1'b0, 32'h010, 32'h0,        2'd1, 1'b0, 32'hFFFFBEEF, 1'b0};
        vt[5]  = '{1'b1, 32'h011, 32'hAAAAAA55, 2'd0, 1'b0, 32'h00000000, 1'b0};
        vt[6]  = '{1'b0, 32'h010, 32'h0,        2'd2, 1'b0, 32'hDEAD55EF, 1'b0};
        vt[7]  = '{1'b0, 32'h012, 32'h0,        2'd2, 1'b0, 32'h00000000, 1'b1};
        vt[8]  = '{1'b1, 32'h011, 32'h00001234, 2'd1, 1'b0, 32'h00000000, 1'b1};
        vt[9]  = '{1'b0, 32'h400, 32'h0,        2'd2, 1'b0, 32'h00000000, 1'b1};
        vt[10] = '{1'b0, 32'h010, 32'h0,        2'd3, 1'b0, 32'h00000000, 1'b1};
        vt[11] = '{1'b1, 32'h400, 32'h12345678, 2'd2, 1'b0, 32'h00000000, 1'b1};
        vt[12] = '{1'b0, 32'h010, 32'h0,        2'd2, 1'b0, 32'hDEAD55EF, 1'b0};
        vt[13] = '{1'b1, 32'h012, 32'h77778001, 2'd1, 1'b0, 32'h00000000, 1'b0};
        vt[14] = '{1'b0, 32'h010, 32'h0,        2'd2, 1'b0, 32'h800155EF, 1'b0};
        vt[15] = '{1'b0, 32'h012, 32'h0,        2'd1, 1'b1, 32'h00008001, 1'b0};
        vt[16] = '{1'b0, 32'h012, 32'h0,        2'd1, 1'b0, 32'hFFFF8001, 1'b0};
        vt[17] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 2'd2, 1'b0, 32'h00000000, 1'b0};
        vt[18] = '{1'b0, 32'h3FF, 32'h0,        2'd0, 1'b0, 32'hFFFFFFCA, 1'b0};
        vt[19] = '{1'b0, 32'hFFFFFFFC, 32'h0,   2'd2, 1'b0, 32'h00000000, 1'b1};

        // Reset values and release.
        @(negedge clk); @(negedge clk);
        chk("rst_req_ready", 32'({bus0.req_ready, bus1.req_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({bus0.rsp_valid, bus1.rsp_valid}), 32'd0);
        chk("rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'({bus0.req_ready, bus1.req_ready}), 32'd3);

        // Fill all RAM so the reference model knows every byte.
        for (int w = 0; w < DEPTH; w++) begin
            logic [31:0] d;
            d = $urandom;
            model(1'b1, 32'(w * 4), d, 2'd2, 1'b0, mrd, me);
            do_txn(1'b1, 32'(w * 4), d, 2'd2, 1'b0, rd0, e0, rd1, e1);
        end

        for (int i = 0; i < 20; i++) begin
            model(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns, mrd, me);
            do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns, rd0, e0, rd1, e1);
            chk($sformatf("vec%0d_rdata0", i), rd0, vt[i].exp_rd);
            chk($sformatf("vec%0d_err0", i), 32'(e0), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_rdata1", i), rd1, vt[i].exp_rd);
            chk($sformatf("vec%0d_err1", i), 32'(e1), 32'(vt[i].exp_err));
        end

        for (int i = 0; i < 200; i++) begin
            we   = 1'($urandom);
            uns  = 1'($urandom);
            size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, DEPTH * 4 - 1));
            nb   = (size == 2'd3) ? 1 : (1 << size);
            if ($urandom_range(0, 9) < 7) addr = addr & ~32'(nb - 1);
            if ($urandom_range(0, 19) == 0) addr = $urandom | 32'h400;
            req_wdata = $urandom;
            model(we, addr, req_wdata, size, uns, mrd, me);
            do_txn(we, addr, req_wdata, size, uns, rd0, e0, rd1, e1);
            chk("rand_rdata0", rd0, mrd);
            chk("rand_err0", 32'(e0), 32'(me));
            chk("rand_rdata1", rd1, mrd);
            chk("rand_err1", 32'(e1), 32'(me));
        end

        // Response stall: held data stays put and new requests are ignored.
        model(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, mrd, me);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        nb = 0;
        while (!bus0.rsp_valid && nb < 20) begin
            @(negedge clk);
            nb++;
        end
        chk("stall_valid_seen", 32'(bus0.rsp_valid), 32'd1);
        held = bus0.rsp_rdata;
        chk("stall_rdata", held, mrd);
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = $urandom;
            @(negedge clk);
            chk("stall_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
            chk("stall_rdata_hold", bus0.rsp_rdata, held);
            chk("stall_req_ready", 32'({bus0.req_ready, bus1.req_ready}), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        do_txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd0, e0, rd1, e1);
        chk("stall_no_write0", rd0, mrd);
        chk("stall_no_write1", rd1, mrd);

        // Reset while the LATENCY=2 instance is BUSY with a store: the store is dropped.
        model(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, mrd, me);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = ~mrd; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_req_ready", 32'({bus0.req_ready, bus1.req_ready}), 32'd0);
        chk("midrst_rsp_valid", 32'({bus0.rsp_valid, bus1.rsp_valid}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(bus0.req_ready), 32'd1);
        chk("midrst_rel_valid", 32'(bus0.rsp_valid), 32'd0);
        do_txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd0, e0, rd1, e1);
        chk("midrst_store_dropped", rd0, mrd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
